// File: rtl/color_select_ctrl_if.sv
// Handshake, board read port and status bundle between the colour-select
// initiator (master) and its surroundings: buttons, game logic and display (slave).
interface color_select_ctrl_if #(
    parameter int unsigned MOVE_W = 6
);
    logic              STARTED_GAME;
    logic [4:0]        SIZE;
    logic [3:0]        COLOR_NUM;
    logic [MOVE_W-1:0] MAX_MOVES;
    logic              BTN_NEXT;
    logic              BTN_PREV;
    logic              BTN_SEL;
    logic              CHANGING_COLOR;
    logic [2:0]        COLOR_SELECTED;
    logic              COLOR_SEL_SIG;
    logic [4:0]        BOARD_ROW;
    logic [4:0]        BOARD_COL;
    logic [2:0]        BOARD_CELL;
    logic [2:0]        CURSOR;
    logic [MOVE_W-1:0] MOVES;
    logic              BUSY;
    logic              WIN;
    logic              LOSE;

    modport master (
        input  STARTED_GAME, SIZE, COLOR_NUM, MAX_MOVES,
        input  BTN_NEXT, BTN_PREV, BTN_SEL, CHANGING_COLOR, BOARD_CELL,
        output COLOR_SELECTED, COLOR_SEL_SIG, BOARD_ROW, BOARD_COL,
        output CURSOR, MOVES, BUSY, WIN, LOSE
    );

    modport slave (
        output STARTED_GAME, SIZE, COLOR_NUM, MAX_MOVES,
        output BTN_NEXT, BTN_PREV, BTN_SEL, CHANGING_COLOR, BOARD_CELL,
        input  COLOR_SELECTED, COLOR_SEL_SIG, BOARD_ROW, BOARD_COL,
        input  CURSOR, MOVES, BUSY, WIN, LOSE
    );
endinterface

// File: rtl/color_select_ctrl.sv
// Flood-fill colour-change initiator: cursor handling, request handshake with the
// game logic, move counting and a serial board scan that decides win or lose.
module color_select_ctrl #(
    parameter int unsigned MOVE_W   = 6,
    parameter int unsigned MAX_SIZE = 26
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    color_select_ctrl_if.master bus
);
    localparam int unsigned AW = $clog2(MAX_SIZE);
    localparam int unsigned CW = 3;
    localparam logic [MOVE_W-1:0] MOVES_SAT = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SCAN,
        S_CHECK,
        S_WON,
        S_LOST
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cursor_q, cursor_d;
    logic [CW-1:0]     sel_q, sel_d;
    logic [CW-1:0]     ref_q, ref_d;
    logic              sig_q, sig_d;
    logic              uniform_q, uniform_d;
    logic              busy_q, busy_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;
    logic [MOVE_W-1:0] moves_q, moves_d;
    logic [AW-1:0]     row_q, row_d;
    logic [AW-1:0]     col_q, col_d;

    logic [3:0]        n_eff_c;
    logic [3:0]        inc_c;
    logic [CW-1:0]     cursor_next_c;
    logic [CW-1:0]     cursor_prev_c;
    logic [AW-1:0]     size_eff_c;
    logic [AW-1:0]     last_c;

    // Clamp the game configuration and precompute cursor neighbours.
    always_comb begin
        n_eff_c = bus.COLOR_NUM;
        if (bus.COLOR_NUM < 4'd2) begin
            n_eff_c = 4'd2;
        end else if (bus.COLOR_NUM > 4'd8) begin
            n_eff_c = 4'd8;
        end

        size_eff_c = AW'(bus.SIZE);
        if ((bus.SIZE < 5'd2) || (32'(bus.SIZE) > MAX_SIZE)) begin
            size_eff_c = AW'(MAX_SIZE);
        end
        last_c = size_eff_c - AW'(1);

        inc_c         = {1'b0, cursor_q} + 4'd1;
        cursor_next_c = (inc_c >= n_eff_c) ? CW'(0) : inc_c[CW-1:0];
        cursor_prev_c = (cursor_q == CW'(0)) ? CW'(n_eff_c - 4'd1) : cursor_q - CW'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        sel_d     = sel_q;
        ref_d     = ref_q;
        sig_d     = sig_q;
        uniform_d = uniform_q;
        moves_d   = moves_q;
        row_d     = '0;
        col_d     = '0;

        if (bus.STARTED_GAME) begin
            state_d = S_IDLE;
            moves_d = '0;
            sig_d   = 1'b0;
            if ({1'b0, cursor_q} >= n_eff_c) begin
                cursor_d = '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.BTN_SEL) begin
                        if (cursor_q != bus.BOARD_CELL) begin
                            sel_d   = cursor_q;
                            sig_d   = 1'b1;
                            state_d = S_REQ;
                        end
                    end else if (bus.BTN_NEXT && !bus.BTN_PREV) begin
                        cursor_d = cursor_next_c;
                    end else if (bus.BTN_PREV && !bus.BTN_NEXT) begin
                        cursor_d = cursor_prev_c;
                    end
                end
                S_REQ: begin
                    if (bus.CHANGING_COLOR) begin
                        sig_d   = 1'b0;
                        moves_d = (moves_q == MOVES_SAT) ? moves_q : moves_q + MOVE_W'(1);
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.CHANGING_COLOR) begin
                        ref_d   = bus.BOARD_CELL;
                        state_d = S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (bus.BOARD_CELL != ref_q) begin
                        uniform_d = 1'b0;
                        state_d   = S_CHECK;
                    end else if ((row_q == last_c) && (col_q == last_c)) begin
                        uniform_d = 1'b1;
                        state_d   = S_CHECK;
                    end else if (col_q == last_c) begin
                        row_d = row_q + AW'(1);
                    end else begin
                        row_d = row_q;
                        col_d = col_q + AW'(1);
                    end
                end
                S_CHECK: begin
                    if (uniform_q) begin
                        state_d = S_WON;
                    end else if ((bus.MAX_MOVES != '0) && (moves_q == bus.MAX_MOVES)) begin
                        state_d = S_LOST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WON, S_LOST: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // While idle the requested colour mirrors the cursor.
        if (state_d == S_IDLE) begin
            sel_d = cursor_d;
        end

        busy_d = !((state_d == S_IDLE) || (state_d == S_WON) || (state_d == S_LOST));
        win_d  = (state_d == S_WON);
        lose_d = (state_d == S_LOST);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            cursor_q  <= '0;
            sel_q     <= '0;
            ref_q     <= '0;
            sig_q     <= 1'b0;
            uniform_q <= 1'b0;
            busy_q    <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            moves_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            sel_q     <= sel_d;
            ref_q     <= ref_d;
            sig_q     <= sig_d;
            uniform_q <= uniform_d;
            busy_q    <= busy_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            moves_q   <= moves_d;
            row_q     <= row_d;
            col_q     <= col_d;
        end
    end

    assign bus.COLOR_SELECTED = sel_q;
    assign bus.COLOR_SEL_SIG  = sig_q;
    assign bus.BOARD_ROW      = 5'(row_q);
    assign bus.BOARD_COL      = 5'(col_q);
    assign bus.CURSOR         = cursor_q;
    assign bus.MOVES          = moves_q;
    assign bus.BUSY           = busy_q;
    assign bus.WIN            = win_q;
    assign bus.LOSE           = lose_q;
endmodule

// File: tb/tb_color_select_ctrl.sv
// Randomised self-checking bench for color_select_ctrl: a board memory, a
// responder for the colour-change handshake and a move-level outcome model.
module tb_color_select_ctrl;
    localparam int unsigned MOVE_W   = 6;
    localparam int          MOVE_MAX = (1 << MOVE_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    color_select_ctrl_if #(.MOVE_W(MOVE_W)) bus ();

    color_select_ctrl #(.MOVE_W(MOVE_W), .MAX_SIZE(26)) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    logic [2:0] board [0:31][0:31];
    always_comb bus.BOARD_CELL = board[bus.BOARD_ROW][bus.BOARD_COL];

    int checks = 0;
    int errors = 0;

    int n_eff, size_eff, max_moves, exp_cursor, exp_moves;
    bit game_over;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp_n(input int c);
        return (c < 2) ? 2 : (c > 8) ? 8 : c;
    endfunction

    function automatic int clamp_size(input int s);
        return (s < 2 || s > 26) ? 26 : s;
    endfunction

    // Raster index of the first cell differing from (0,0), or -1 if uniform.
    function automatic int first_mismatch();
        for (int i = 0; i < size_eff * size_eff; i++) begin
            if (board[i / size_eff][i % size_eff] != board[0][0]) return i;
        end
        return -1;
    endfunction

    task automatic press(input bit nx, input bit pv, input bit sl);
        bus.BTN_NEXT = nx;
        bus.BTN_PREV = pv;
        bus.BTN_SEL  = sl;
        tick();
        bus.BTN_NEXT = 1'b0;
        bus.BTN_PREV = 1'b0;
        bus.BTN_SEL  = 1'b0;
    endtask

    task automatic cursor_step(input bit nx, input bit pv);
        press(nx, pv, 1'b0);
        if (!game_over) begin
            if (nx && !pv) exp_cursor = (exp_cursor + 1) % n_eff;
            else if (pv && !nx) exp_cursor = (exp_cursor == 0) ? n_eff - 1 : exp_cursor - 1;
            check_eq("idle_color_sel", bus.COLOR_SELECTED, exp_cursor);
        end
        check_eq("cursor", bus.CURSOR, exp_cursor);
    endtask

    task automatic start_game(input int size, input int cnum, input int maxm);
        bus.SIZE         = 5'(size);
        bus.COLOR_NUM    = 4'(cnum);
        bus.MAX_MOVES    = MOVE_W'(maxm);
        n_eff            = clamp_n(cnum);
        size_eff         = clamp_size(size);
        max_moves        = maxm;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                board[r][c] = 3'($urandom_range(0, n_eff - 1));
        bus.STARTED_GAME = 1'b1;
        tick();
        bus.STARTED_GAME = 1'b0;
        exp_moves = 0;
        if (exp_cursor >= n_eff) exp_cursor = 0;
        game_over = 1'b0;
        check_eq("start_moves", bus.MOVES, 0);
        check_eq("start_flags", {bus.WIN, bus.LOSE, bus.BUSY, bus.COLOR_SEL_SIG}, 0);
        check_eq("start_cursor", bus.CURSOR, exp_cursor);
        check_eq("start_addr", {bus.BOARD_ROW, bus.BOARD_COL}, 0);
    endtask

    function automatic int pick_colour();
        int c;
        do c = $urandom_range(0, n_eff - 1); while (c == int'(board[0][0]));
        return c;
    endfunction

    // Navigate the cursor to c, commit it and let the responder acknowledge.
    task automatic launch(input int c, input int delay);
        int guard = 0;
        while (exp_cursor != c && guard < 16) begin
            cursor_step(1'b1, 1'b0);
            guard++;
        end
        press(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        check_eq("sel_sig", bus.COLOR_SEL_SIG, 1);
        check_eq("sel_color", bus.COLOR_SELECTED, c);
        check_eq("sel_cursor_hold", bus.CURSOR, c);
        check_eq("sel_busy", bus.BUSY, 1);
        repeat (delay) begin
            tick();
            check_eq("req_hold", {bus.COLOR_SEL_SIG, bus.COLOR_SELECTED}, {1'b1, 3'(c)});
        end
        bus.CHANGING_COLOR = 1'b1;
        tick();
        if (exp_moves < MOVE_MAX) exp_moves++;
        check_eq("ack_sig_drop", bus.COLOR_SEL_SIG, 0);
        check_eq("ack_moves", bus.MOVES, exp_moves);
    endtask

    // Responder's fill: 1 uniform, 2 only the far corner differs, 0 random.
    task automatic apply_board(input int mode, input int c);
        int lst = size_eff - 1;
        if (mode != 0 || $urandom_range(0, 1) == 1) begin
            for (int r = 0; r < size_eff; r++)
                for (int k = 0; k < size_eff; k++)
                    board[r][k] = 3'(c);
        end
        board[0][0] = 3'(c);
        if (mode == 2) begin
            board[lst][lst] = 3'((c + 1) % n_eff);
        end else if (mode == 0) begin
            repeat ($urandom_range(0, 2))
                board[$urandom_range(0, lst)][$urandom_range(0, lst)] = 3'($urandom_range(0, n_eff - 1));
        end
    endtask

    task automatic finish_move(input int hold);
        int k, exp_lat, cnt;
        bit uni, exp_lose;
        repeat (hold) begin
            tick();
            check_eq("wait_sig_low", {bus.COLOR_SEL_SIG, bus.BUSY}, 2'b01);
        end
        k        = first_mismatch();
        uni      = (k < 0);
        exp_lat  = uni ? size_eff * size_eff + 2 : k + 3;
        exp_lose = !uni && max_moves != 0 && exp_moves == max_moves;
        bus.CHANGING_COLOR = 1'b0;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.BUSY === 1'b1 && cnt < 2000);
        check_eq("scan_latency", cnt, exp_lat);
        check_eq("win", bus.WIN, uni);
        check_eq("lose", bus.LOSE, exp_lose);
        check_eq("moves", bus.MOVES, exp_moves);
        check_eq("sig_after", bus.COLOR_SEL_SIG, 0);
        game_over = uni || exp_lose;
        if (!game_over) begin
            check_eq("idle_addr", {bus.BOARD_ROW, bus.BOARD_COL}, 0);
            check_eq("idle_color_sel", bus.COLOR_SELECTED, exp_cursor);
        end
    endtask

    task automatic full_move(input int mode, input int delay, input int hold);
        int c = pick_colour();
        launch(c, delay);
        apply_board(mode, c);
        finish_move(hold);
    endtask

    task automatic check_ignored();
        cursor_step(1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check_eq("over_no_sig", bus.COLOR_SEL_SIG, 0);
        check_eq("over_busy", bus.BUSY, 0);
    endtask

    initial begin
        bus.STARTED_GAME   = 1'b0;
        bus.SIZE           = 5'd6;
        bus.COLOR_NUM      = 4'd6;
        bus.MAX_MOVES      = '0;
        bus.BTN_NEXT       = 1'b0;
        bus.BTN_PREV       = 1'b0;
        bus.BTN_SEL        = 1'b0;
        bus.CHANGING_COLOR = 1'b0;
        exp_cursor = 0;
        exp_moves  = 0;
        game_over  = 1'b0;
        n_eff      = 6;
        size_eff   = 6;
        max_moves  = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                board[r][c] = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_outputs", {bus.COLOR_SEL_SIG, bus.COLOR_SELECTED, bus.CURSOR, bus.BUSY, bus.WIN, bus.LOSE}, 0);
        check_eq("rst_moves", bus.MOVES, 0);
        check_eq("rst_addr", {bus.BOARD_ROW, bus.BOARD_COL}, 0);
        rst_n = 1'b1;
        tick();

        // Cursor wrap behaviour with six colours.
        start_game(6, 6, 0);
        repeat (7) cursor_step(1'b1, 1'b0);
        check_eq("cursor_7_next", bus.CURSOR, 1);
        cursor_step(1'b0, 1'b1);
        cursor_step(1'b0, 1'b1);
        check_eq("cursor_prev_wrap", bus.CURSOR, 5);
        cursor_step(1'b1, 1'b1);
        check_eq("cursor_both", bus.CURSOR, 5);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0)
                start_game($urandom_range(0, 31), $urandom_range(0, 15), 0);
            else
                cursor_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Select on the colour already at the origin does nothing.
        board[0][0] = 3'(exp_cursor);
        press(1'b0, 1'b0, 1'b1);
        check_eq("same_sel_sig", bus.COLOR_SEL_SIG, 0);
        check_eq("same_sel_busy", bus.BUSY, 0);
        tick();
        check_eq("same_sel_moves", bus.MOVES, exp_moves);

        // Directed handshake and win.
        start_game(6, 6, 0);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                board[r][c] = 3'd1;
        launch(3, 5);
        check_eq("first_move", bus.MOVES, 1);
        board[0][0] = 3'd3;
        finish_move(2);
        launch(2, 0);
        apply_board(1, 2);
        finish_move(1);
        check_eq("win_directed", bus.WIN, 1);
        check_ignored();
        check_eq("win_sticky", bus.WIN, 1);
        start_game(6, 6, 0);

        // Move budget of two on a board that never becomes uniform.
        start_game(6, 6, 2);
        full_move(2, 1, 0);
        check_eq("lose_not_yet", bus.LOSE, 0);
        full_move(2, 0, 1);
        check_eq("lose_directed", bus.LOSE, 1);
        check_ignored();
        check_eq("lose_sticky", bus.LOSE, 1);

        // Unlimited budget saturates the move counter.
        start_game(6, 6, 0);
        for (int i = 0; i < 70; i++) full_move(2, 0, 0);
        check_eq("moves_saturated", bus.MOVES, MOVE_MAX);
        check_eq("no_lose_unlimited", bus.LOSE, 0);

        // Asynchronous reset while waiting for the busy window to end.
        start_game(6, 6, 0);
        launch(pick_colour(), 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_wait_flags", {bus.COLOR_SEL_SIG, bus.COLOR_SELECTED, bus.CURSOR, bus.BUSY, bus.WIN, bus.LOSE}, 0);
        check_eq("rst_wait_moves", bus.MOVES, 0);
        exp_cursor = 0;
        exp_moves  = 0;
        bus.CHANGING_COLOR = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst_release_idle", {bus.BUSY, bus.COLOR_SEL_SIG}, 0);

        // New game while scanning.
        launch(pick_colour(), 0);
        apply_board(2, exp_cursor);
        bus.CHANGING_COLOR = 1'b0;
        repeat (3) tick();
        check_eq("scan_busy", bus.BUSY, 1);
        check_eq("scan_col", bus.BOARD_COL, 2);
        start_game(6, 6, 0);

        // Randomised games.
        for (int g = 0; g < 6; g++) begin
            start_game($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 4));
            for (int m = 0; m < 8 && !game_over; m++)
                full_move($urandom_range(0, 2), $urandom_range(0, 5), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
